iic_slave_rx: RTL

- I2C write-only responder: the receiving end of the iic_opr master.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address, ACKs on the bus and presents received data bytes on a valid/ready stream.
- Used for loopback bring-up of iic_opr and as a register-write target for on-board masters.

---
 rtl/iic_slave_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/iic_slave_rx.sv
// I2C write-only responder: oversampled START/STOP detection, 7-bit address match,
// bus ACK and valid/ready byte stream. Optional majority filter: IIC_RX_GLITCH_FILTER_EN.
module iic_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       SCL,
  input  logic       SDA,
  output logic       sda_oe,
  output logic       m_tvalid,
  output logic [7:0] m_tdata,
  input  logic       m_tready,
  output logic       busy,
  output logic       stop_det,
  output logic       overrun
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_DATA_ACK = 3'd4;
  localparam logic [2:0] ST_IGNORE   = 3'd5;

  // Idle bus is high, so synchronisers reset to 1 to avoid a false edge after reset
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
    end
  end

  logic scl_s, sda_s;
`ifdef IIC_RX_GLITCH_FILTER_EN
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  logic [2:0] scl_hist, sda_hist;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_s    <= 1'b1;
      sda_s    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[SYNC_STAGES-1]};
      sda_hist <= {sda_hist[1:0], sda_sync[SYNC_STAGES-1]};
      scl_s    <= maj3(scl_hist);
      sda_s    <= maj3(sda_hist);
    end
  end
`else
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

  logic scl_d, sda_d;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c;
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign sda_rise = sda_s & ~sda_d;
  assign sda_fall = ~sda_s & sda_d;
  assign start_c  = sda_fall & scl_s;
  assign stop_c   = sda_rise & scl_s;

  logic [2:0] state;
  logic [3:0] bit_cnt;   // counts to 8 so the 9th-clock fall can be told apart
  logic [7:0] shift;
  logic       byte_done, addr_hit, sampling;

  assign byte_done = (bit_cnt == 4'd8);
  assign addr_hit  = (shift[7:1] == SLAVE_ADDR) && !shift[0];
  assign sampling  = ((state == ST_ADDR) || (state == ST_DATA)) && !byte_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      sda_oe   <= 1'b0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      busy     <= 1'b0;
      stop_det <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      stop_det <= 1'b0;
      // Load below may re-assert valid in the same cycle for back-to-back bytes
      if (m_tvalid && m_tready) m_tvalid <= 1'b0;

      if (start_c) begin
        state   <= ST_ADDR;
        busy    <= 1'b1;
        overrun <= 1'b0;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop_c) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        stop_det <= 1'b1;
        sda_oe   <= 1'b0;
        bit_cnt  <= '0;
      end else begin
        if (scl_rise && sampling) begin
          shift   <= {shift[6:0], sda_s};
          bit_cnt <= bit_cnt + 4'd1;
        end
        case (state)
          ST_ADDR: begin
            if (scl_fall && byte_done) begin
              if (addr_hit) begin
                sda_oe <= 1'b1;
                state  <= ST_ADDR_ACK;
              end else begin
                state  <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK, ST_DATA_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (scl_fall && byte_done) begin
              if (!m_tvalid || m_tready) begin
                m_tdata  <= shift;
                m_tvalid <= 1'b1;
                sda_oe   <= 1'b1;
              end else begin
                sda_oe   <= 1'b0;
                overrun  <= 1'b1;
              end
              state <= ST_DATA_ACK;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
